// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants, FSM encoding and width helper for the RAM port arbiter.
package ram_port_arbiter_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_OWNED = 1'b1
  } arb_state_t;

  // Index width that never collapses to zero bits.
  function automatic int id_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Cache-side and RAM-side bus of the arbiter; master is the arbiter's view.
interface ram_port_arbiter_if #(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = ram_port_arbiter_pkg::DEF_DATA_W,
  parameter int ADDR_W  = ram_port_arbiter_pkg::DEF_ADDR_W
);
  logic [N_PORTS*DATA_W-1:0] c_data_w;
  logic [N_PORTS*ADDR_W-1:0] c_addr;
  logic [N_PORTS-1:0]        c_read;
  logic [N_PORTS-1:0]        c_write;
  logic [N_PORTS-1:0]        c_atomic;
  logic [N_PORTS-1:0]        c_wait;
  logic [DATA_W-1:0]         c_data_r;
  logic [DATA_W-1:0]         ram_data_w;
  logic [ADDR_W-1:0]         ram_addr;
  logic                      ram_read;
  logic                      ram_write;
  logic                      ram_atomic;
  logic                      ram_wait;
  logic [DATA_W-1:0]         ram_data_r;

  modport master (
    input  c_data_w, c_addr, c_read, c_write, c_atomic, ram_wait, ram_data_r,
    output c_wait, c_data_r, ram_data_w, ram_addr, ram_read, ram_write, ram_atomic
  );

  modport slave (
    output c_data_w, c_addr, c_read, c_write, c_atomic, ram_wait, ram_data_r,
    input  c_wait, c_data_r, ram_data_w, ram_addr, ram_read, ram_write, ram_atomic
  );
endinterface

// File: rtl/ram_port_arbiter_rr_pick.sv
// Combinational round-robin selector: first requester after last_grant, wrapping.
module rr_pick
  import ram_port_arbiter_pkg::*;
#(
  parameter int N_PORTS = 4,
  localparam int ID_W   = id_width(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [ID_W-1:0]    last_grant,
  output logic [ID_W-1:0]    winner,
  output logic               any_req
);

  logic [ID_W-1:0]    cand [N_PORTS];
  logic [N_PORTS-1:0] hit;

  // cand[i] is the port at rotation distance i+1 from the previous owner.
  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_rot
      assign cand[gi] = ID_W'((int'(last_grant) + gi + 1) % N_PORTS);
      assign hit[gi]  = req[cand[gi]];
    end
  endgenerate

  always_comb begin
    winner = '0;
    for (int i = N_PORTS - 1; i >= 0; i--) begin
      if (hit[i]) winner = cand[i];
    end
  end

  assign any_req = |req;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM port among N_PORTS caches; round-robin, grant held for a whole burst/atomic.
module ram_port_arbiter
  import ram_port_arbiter_pkg::*;
#(
  parameter int N_PORTS    = 4,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int HOLD_LIMIT = 1024,
  localparam int ID_W      = id_width(N_PORTS)
) (
  input  logic               clk,
  input  logic               reset_n,
  ram_port_arbiter_if.master bus,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  output logic               timeout_err
);

  localparam int CNT_W = $clog2(HOLD_LIMIT + 1);

  arb_state_t         state_reg, state_next;
  logic [ID_W-1:0]    grant_id_reg, last_grant_reg, winner;
  logic [CNT_W-1:0]   hold_cnt_reg, hold_cnt_next;
  logic               timeout_err_reg, any_req, owner_req;
  logic [N_PORTS-1:0] req, c_wait_vec;
  logic [DATA_W-1:0]  data_w_arr [N_PORTS];
  logic [ADDR_W-1:0]  addr_arr [N_PORTS];

  generate
    for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
      assign req[gi]        = bus.c_read[gi] | bus.c_write[gi] | bus.c_atomic[gi];
      assign data_w_arr[gi] = bus.c_data_w[gi*DATA_W +: DATA_W];
      assign addr_arr[gi]   = bus.c_addr[gi*ADDR_W +: ADDR_W];
      // Only the owner sees the RAM stall; everyone else stalls on its own request.
      assign c_wait_vec[gi] = (state_reg == ARB_OWNED && grant_id_reg == ID_W'(gi))
                              ? bus.ram_wait : req[gi];
    end
  endgenerate

  rr_pick #(.N_PORTS(N_PORTS)) u_rr_pick (
    .req        (req),
    .last_grant (last_grant_reg),
    .winner     (winner),
    .any_req    (any_req)
  );

  assign owner_req     = req[grant_id_reg];
  assign hold_cnt_next = (hold_cnt_reg == CNT_W'(HOLD_LIMIT)) ? hold_cnt_reg
                                                              : hold_cnt_reg + 1'b1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ARB_IDLE;
    else          state_reg <= state_next;
  end

  // Release always passes through IDLE, so a new winner is never picked on the release edge.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE:  if (any_req)    state_next = ARB_OWNED;
      ARB_OWNED: if (!owner_req) state_next = ARB_IDLE;
      default:                   state_next = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant_id_reg    <= '0;
      last_grant_reg  <= ID_W'(N_PORTS - 1);
      hold_cnt_reg    <= '0;
      timeout_err_reg <= 1'b0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (any_req) begin
            grant_id_reg   <= winner;
            last_grant_reg <= winner;
            hold_cnt_reg   <= '0;
          end
        end
        ARB_OWNED: begin
          hold_cnt_reg <= hold_cnt_next;
          if (hold_cnt_next == CNT_W'(HOLD_LIMIT)) timeout_err_reg <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.ram_read   = 1'b0;
    bus.ram_write  = 1'b0;
    bus.ram_atomic = 1'b0;
    bus.ram_addr   = '0;
    bus.ram_data_w = '0;
    if (state_reg == ARB_OWNED) begin
      bus.ram_read   = bus.c_read[grant_id_reg];
      bus.ram_write  = bus.c_write[grant_id_reg];
      bus.ram_atomic = bus.c_atomic[grant_id_reg];
      bus.ram_addr   = addr_arr[grant_id_reg];
      bus.ram_data_w = data_w_arr[grant_id_reg];
    end
  end

  assign bus.c_wait   = c_wait_vec;
  assign bus.c_data_r = bus.ram_data_r;
  assign busy         = (state_reg == ARB_OWNED);
  assign grant_id     = grant_id_reg;
  assign timeout_err  = timeout_err_reg;

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the single RAM port between N_PORTS private caches (one per core) in the multicore system.
- Sits between the caches' RAM-side interface (ram_* outputs of each cache) and the RAM/memory controller.
- Round-robin arbitration with grant lock for the full duration of a line burst (16-word fill or write-back) and for atomic sequences, so one cache's accesses are never interleaved with another's.

Parameters:
- N_PORTS, 4, number of cache requesters (2..8).
- DATA_W, 32, data width (matches `DATA_W in core/defines.vh).
- ADDR_W, 32, address width (matches `DATA_ADDR_W).
- HOLD_LIMIT, 1024, max cycles one grant may last before timeout_err is raised (atomic and bursts included).

Ports:
- clk  in  1  system clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- c_data_w  in  N_PORTS*DATA_W  write data per cache, port k at [k*DATA_W +: DATA_W].
- c_addr  in  N_PORTS*ADDR_W  address per cache.
- c_read  in  N_PORTS  read request per cache.
- c_write  in  N_PORTS  write request per cache.
- c_atomic  in  N_PORTS  atomic lock request per cache.
- c_wait  out  N_PORTS  stall to each cache.
- c_data_r  out  DATA_W  read data, broadcast to all caches.
- ram_data_w  out  DATA_W  to RAM.
- ram_addr  out  ADDR_W  to RAM.
- ram_read  out  1  to RAM.
- ram_write  out  1  to RAM.
- ram_atomic  out  1  to RAM.
- ram_wait  in  1  RAM stall.
- ram_data_r  in  DATA_W  RAM read data.
- grant_id  out  clog2(N_PORTS)  index of current owner, valid when busy=1.
- busy  out  1  a grant is active.
- timeout_err  out  1  sticky; grant exceeded HOLD_LIMIT.

Behaviour:
- Request definition: req[k] = c_read[k] | c_write[k] | c_atomic[k].
- FSM states: IDLE, OWNED.
- Reset (async, reset_n=0):
  - state=IDLE, busy=0, grant_id=0.
  - last_grant=N_PORTS-1, so port 0 wins first.
  - hold_cnt=0, timeout_err=0.
  - ram_read/ram_write/ram_atomic=0; ram_addr and ram_data_w=0.
  - c_wait[k]=req[k].
- IDLE:
  - RAM outputs: read/write/atomic=0, addr/data_w=0.
  - c_wait[k]=req[k]; a requester always stalls in IDLE.
  - If any req: winner = first requester scanning from last_grant+1 upward with wrap at N_PORTS-1 -> 0.
  - Next edge: state=OWNED, grant_id=winner, last_grant=winner, hold_cnt=0.
  - Arbitration latency: exactly 1 cycle from request to first forwarded cycle.
- OWNED:
  - Combinational pass-through of the owner's data_w/addr/read/write/atomic to ram_*.
  - c_wait[grant_id]=ram_wait.
  - c_wait[k≠grant_id]=req[k]; non-requesters see 0.
  - c_data_r=ram_data_r always, in every state.
  - hold_cnt increments each cycle and saturates at HOLD_LIMIT.
- Release and re-arbitration:
  - When req[grant_id]==0 in a cycle, next edge: state=IDLE, busy=0.
  - Grant is held regardless of ram_wait.
  - A new winner is never chosen in the same cycle as release: one idle bubble minimum, which gives round-robin fairness.
- Atomic lock: while c_atomic[grant_id]=1 the grant is held even if read/write both drop. Other ports stall until atomic deasserts.
- Read and write asserted together by the owner: both are forwarded unchanged. Resolving that is the RAM's responsibility.
- Timeout: if hold_cnt reaches HOLD_LIMIT while OWNED, timeout_err is set to 1 (sticky until reset).
  - The grant is NOT revoked; timeout is diagnostic only.
- Simultaneous requests from all ports with continuous demand: the grant order is 0,1,2,3,0,...
  - No port waits more than N_PORTS-1 foreign grants.
- Owner drops req while ram_wait=1: the release still occurs. The RAM must tolerate the abandoned access; the cache protocol forbids this.
- Reset mid-burst: ram_read/ram_write drop asynchronously; no partial-burst recovery.
- Width rules:
  - grant_id width = max(1, clog2(N_PORTS)).
  - hold_cnt width = clog2(HOLD_LIMIT+1).

Decomposition:
- Shared package/defines (core/defines.vh): DATA_W, DATA_ADDR_W, FSM state encodings ARB_IDLE=1'b0 and ARB_OWNED=1'b1.
- One sub-module: rr_pick.
  - Combinational round-robin priority selector.
  - Inputs: req vector, last_grant.
  - Outputs: winner index, any_req.
  - Unit-tested separately.
- The mux/demux and FSM live in the top module.

Test Plan:
- Single port: port 2 raises c_read with addr 0x0001_2340 at cycle 0.
  - Cycle 0: c_wait[2]=1.
  - Cycle 1: busy=1, grant_id=2, ram_read=1, ram_addr=0x0001_2340.
  - c_data_r follows ram_data_r.
- Contention: ports 0,1,3 request simultaneously with 16-cycle bursts.
  - Grant order 0,1,3.
  - One IDLE cycle between grants.
  - Stalled ports see c_wait=1 throughout.
  - No ram_addr from a non-owner ever appears.
- Atomic hold: port 1 asserts c_atomic plus read, drops read for 5 cycles, then writes, then drops atomic; port 0 requests meanwhile.
  - Port 0 is granted only after c_atomic[1] falls.
  - ram_atomic=1 during the hold.
- ram_wait propagation: owner port 3 with ram_wait toggling 1,0,1,0.
  - c_wait[3] mirrors ram_wait exactly.
  - Other requesting ports hold c_wait=1.
- Timeout: HOLD_LIMIT=8, owner holds req 12 cycles.
  - timeout_err rises on the 8th owned cycle and stays 1 after release.
  - It clears only on reset_n=0.
- Async reset mid-burst: reset_n pulses low between clock edges while port 1 owns the grant.
  - ram_read/ram_write=0 and busy=0 immediately.
  - After release, port 0 is granted first.
